// File: rtl/proj_sel_scheduler.sv
// rtl/proj_sel_scheduler.sv - project select sequencer for the user-area output mux
//
// Owns the project select of the output multiplexer. Every switch runs
// BLANK (pads forced low) -> HOLDRST (select retargeted, new project in
// reset) -> ACTIVE (project released). Unselected projects stay in reset.
// Optional autoscan (build macro SCHED_AUTOSCAN_EN) rotates through all
// projects, spending DWELL_CYCLES active cycles on each.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   req_valid   host select request valid
//   req_sel     requested project index (out-of-range maps to 0)
//   req_ready   request accepted when req_valid && req_ready at a rising edge
//   scan_en     autoscan enable (only honoured with SCHED_AUTOSCAN_EN)
//   sel         mux select
//   blank       1 = pads forced to 0
//   proj_rst_n  per-project active-low reset
//   active      selected project is running
module proj_sel_scheduler #(
  parameter int NPROJ        = 13,
  parameter int GUARD_CYCLES = 2,
  parameter int RST_CYCLES   = 4,
  parameter int DWELL_CYCLES = 256,
  parameter int DEFAULT_SEL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [3:0]       req_sel,
  output logic             req_ready,
  input  logic             scan_en,
  output logic [3:0]       sel,
  output logic             blank,
  output logic [NPROJ-1:0] proj_rst_n,
  output logic             active
);

  typedef enum logic [1:0] {
    ST_BLANK   = 2'd0,
    ST_HOLDRST = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  // One shared phase counter serves both BLANK and HOLDRST; it only has to
  // reach the larger of the two terminal counts.
  localparam int CMAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]    GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0]    RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [3:0]       SEL_LAST   = 4'(NPROJ - 1);
  localparam logic [3:0]       SEL_RESET  = 4'(DEFAULT_SEL);
  localparam logic [NPROJ-1:0] ONE_HOT0   = NPROJ'(1);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [3:0]      pending;
  logic [3:0]      pending_nx;
  logic [3:0]      sel_nx;
  logic            host_take;
  logic            scan_take;

  // Indices beyond the last project fall onto project 0, the same place the
  // mux default arm sends them.
  function automatic logic [3:0] map_sel(input logic [3:0] s);
    return (int'(s) >= NPROJ) ? 4'd0 : s;
  endfunction

  assign host_take = req_valid && (state == ST_ACTIVE);

`ifdef SCHED_AUTOSCAN_EN
  localparam int            DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  logic [DW-1:0] dwell;

  // Internal rotation request on the last dwell cycle; a host request in the
  // same cycle takes priority in the next-state logic.
  assign scan_take = (state == ST_ACTIVE) && scan_en && (dwell == DWELL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell <= '0;
    end else if ((state != ST_ACTIVE) || !scan_en || host_take || scan_take) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en;
  assign scan_take      = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    pending_nx = pending;
    sel_nx     = sel;
    case (state)
      ST_BLANK: begin
        // Select only moves at the end of blanking, so it never changes
        // while the pads are driven.
        if (cnt == GUARD_LAST) begin
          state_nx = ST_HOLDRST;
          cnt_nx   = '0;
          sel_nx   = pending;
        end
      end
      ST_HOLDRST: begin
        if (cnt == RST_LAST) begin
          state_nx = ST_ACTIVE;
          cnt_nx   = '0;
        end
      end
      ST_ACTIVE: begin
        cnt_nx = '0;
        if (host_take) begin
          state_nx   = ST_BLANK;
          pending_nx = map_sel(req_sel);
        end else if (scan_take) begin
          state_nx   = ST_BLANK;
          pending_nx = (sel == SEL_LAST) ? 4'd0 : sel + 4'd1;
        end
      end
      default: begin
        state_nx = ST_HOLDRST;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state register without any input-to-output combinational path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_HOLDRST;
      cnt        <= '0;
      pending    <= SEL_RESET;
      sel        <= SEL_RESET;
      blank      <= 1'b1;
      active     <= 1'b0;
      req_ready  <= 1'b0;
      proj_rst_n <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pending    <= pending_nx;
      sel        <= sel_nx;
      blank      <= (state_nx != ST_ACTIVE);
      active     <= (state_nx == ST_ACTIVE);
      req_ready  <= (state_nx == ST_ACTIVE);
      proj_rst_n <= (state_nx == ST_ACTIVE) ? (ONE_HOT0 << sel_nx) : '0;
    end
  end

endmodule

// File: tb/tb_proj_sel_scheduler.sv
// tb/tb_proj_sel_scheduler.sv - self-checking bench for proj_sel_scheduler
module tb_proj_sel_scheduler;

  localparam int NP    = 13;
  localparam int GUARD = 2;
  localparam int RSTC  = 4;
  localparam int DWELL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_sel = 4'd0;
  logic          scan_en = 1'b0;
  logic          req_ready;
  logic [3:0]    sel;
  logic          blank;
  logic [NP-1:0] proj_rst_n;
  logic          active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  proj_sel_scheduler #(
    .NPROJ(NP), .GUARD_CYCLES(GUARD), .RST_CYCLES(RSTC),
    .DWELL_CYCLES(DWELL), .DEFAULT_SEL(0)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .scan_en(scan_en), .sel(sel), .blank(blank),
    .proj_rst_n(proj_rst_n), .active(active)
  );

  // Reference model: time since the last accepted switch (or reset) decides
  // everything. The select moves GUARD edges after acceptance and the project
  // runs GUARD+RSTC edges after acceptance (RSTC edges after reset).
  int m_t;
  bit m_boot;
  int m_sel;
  int m_pend;
  int m_run;

  function automatic bit m_active();
    return m_t >= (m_boot ? RSTC : GUARD + RSTC);
  endfunction

  task automatic model_reset();
    m_t = 0; m_boot = 1; m_sel = 0; m_pend = 0; m_run = 0;
  endtask

  task automatic model_edge();
    bit act;
    bit take;
    int tgt;
    act = m_active();
    take = 0;
    tgt = 0;
    if (act) begin
      if (req_valid) begin
        take = 1;
        tgt = (req_sel < NP) ? int'(req_sel) : 0;
      end
`ifdef SCHED_AUTOSCAN_EN
      else if (scan_en && m_run == DWELL - 1) begin
        take = 1;
        tgt = (m_sel + 1) % NP;
      end
`endif
    end
    if (act && scan_en && !take) m_run++;
    else m_run = 0;
    if (take) begin
      m_t = 0; m_boot = 0; m_pend = tgt;
    end else if (m_t < 100) begin
      m_t++;
    end
    if (!m_boot && m_t == GUARD) m_sel = m_pend;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic report(input string tag, input int esel, input bit eb, input logic [NP-1:0] ep);
    n_cmp++;
    if (sel !== 4'(esel) || blank !== eb || active !== !eb || req_ready !== !eb || proj_rst_n !== ep) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d blank=%b active=%b ready=%b prst=%h, want sel=%0d blank=%b active=%b ready=%b prst=%h",
               tag, sel, blank, active, req_ready, proj_rst_n, esel, eb, !eb, !eb, ep);
    end
  endtask

  task automatic expect_out(input string tag, input int esel, input bit eb);
    logic [NP-1:0] ep;
    ep = eb ? '0 : (NP'(1) << esel);
    report(tag, esel, eb, ep);
  endtask

  task automatic check_model(input string tag);
    bit a;
    logic [NP-1:0] ep;
    a = m_active();
    ep = a ? (NP'(1) << m_sel) : '0;
    report(tag, m_sel, !a, ep);
  endtask

  typedef struct {
    bit         v;
    logic [3:0] s;
    int         esel;
    bit         eblank;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit v, input int s, input int esel, input bit eb);
    vec_t r;
    r.v = v; r.s = 4'(s); r.esel = esel; r.eblank = eb;
    for (int i = 0; i < n; i++) tbl.push_back(r);
  endtask

  initial begin
    // boot, then switch to 5, switch to 14 (maps to 0), switch to 9 with a
    // held request for 2 that lands on the first ACTIVE cycle
    add(3, 0, 0, 0, 1);  add(1, 0, 0, 0, 0);
    add(1, 1, 5, 0, 1);  add(1, 0, 0, 0, 1);  add(4, 0, 0, 5, 1);  add(1, 0, 0, 5, 0);
    add(1, 1, 14, 5, 1); add(1, 0, 0, 5, 1);  add(4, 0, 0, 0, 1);  add(1, 0, 0, 0, 0);
    add(1, 1, 9, 0, 1);  add(1, 1, 2, 0, 1);  add(4, 1, 2, 9, 1);  add(1, 1, 2, 9, 0);
    add(1, 1, 2, 9, 1);  add(1, 0, 0, 9, 1);  add(4, 0, 0, 2, 1);  add(1, 0, 0, 2, 0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 1);
    @(negedge clk) rst = 1'b1;

    foreach (tbl[i]) begin
      req_valid = tbl[i].v;
      req_sel   = tbl[i].s;
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].esel, tbl[i].eblank);
    end
    req_valid = 1'b0;

    // reset during HOLDRST of a switch to 7
    req_valid = 1'b1; req_sel = 4'd7;
    tick();
    req_valid = 1'b0;
    expect_out("sw7_blank", 2, 1);
    repeat (3) tick();
    expect_out("sw7_hold", 7, 1);
    #2 rst = 1'b0;
    model_reset();
    #1 expect_out("rst_async", 0, 1);
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();
    expect_out("rst_boot", 0, 1);
    tick();
    expect_out("rst_done", 0, 0);

`ifdef SCHED_AUTOSCAN_EN
    req_valid = 1'b1; req_sel = 4'd12;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    expect_out("to12", 12, 0);
    scan_en = 1'b1;
    repeat (7) tick();
    expect_out("dwell_hold", 12, 0);
    tick();
    expect_out("dwell_exp", 12, 1);
    repeat (2) tick();
    expect_out("wrap_sel", 0, 1);
    repeat (4) tick();
    expect_out("wrap_act", 0, 0);
    repeat (7) tick();
    req_valid = 1'b1; req_sel = 4'd3;
    tick();
    req_valid = 1'b0;
    scan_en = 1'b0;
    expect_out("host_win", 0, 1);
    repeat (5) tick();
    expect_out("host_win_act", 3, 0);
`else
    scan_en = 1'b1;
    repeat (20) tick();
    expect_out("noscan", 0, 0);
    scan_en = 1'b0;
`endif

    // randomized traffic against the model, with occasional async resets
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 9) < 2);
      req_sel   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) scan_en = ~scan_en;
      tick();
      check_model("rand");
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        #1 check_model("rand_rst");
        @(negedge clk) rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proj_sel_scheduler.md
# proj_sel_scheduler

Controller for the 13-way project output multiplexer in the user area. It owns the 4-bit project select, and sequences every switch between student projects:
- blank the pads;
- retarget the select;
- hold the newly selected project in reset;
- release it.

Unselected projects are held in reset. An optional autoscan mode rotates through all projects on a fixed dwell. The block sits between the host-facing select request and the output mux / per-project reset pins.

## Interface
Parameters:
- NPROJ, 13: number of projects; valid select range is 0..NPROJ-1.
- GUARD_CYCLES, 2: blanking cycles before the select changes (>=1).
- RST_CYCLES, 4: cycles the new project is held in reset after the select changes (>=1).
- DWELL_CYCLES, 256: ACTIVE cycles per project in autoscan (>=1).
- DEFAULT_SEL, 0: select value loaded at reset.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  host select request valid.
- req_sel  in  4  requested project index.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- scan_en  in  1  autoscan enable; ignored unless SCHED_AUTOSCAN_EN is defined.
- sel  out  4  mux select.
- blank  out  1  1 = the top level forces io_out to 0.
- proj_rst_n  out  NPROJ  per-project active-low reset.
- active  out  1  selected project is running.

## Operation
- Reset values (rst low):
  - state = HOLDRST, sel = DEFAULT_SEL, counter = 0.
  - blank = 1, active = 0, req_ready = 0.
  - proj_rst_n = all 0, dwell counter = 0.
- States:
  - BLANK: blank=1, sel unchanged, all proj_rst_n=0.
  - HOLDRST: blank=1, all proj_rst_n=0.
  - ACTIVE: blank=0, active=1, req_ready=1, proj_rst_n = one-hot(sel), all other bits 0.
- BLANK -> HOLDRST after GUARD_CYCLES cycles. sel loads the pending index on that same edge.
- HOLDRST -> ACTIVE after RST_CYCLES cycles. The counter clears on every state entry.
- ACTIVE -> BLANK on an accepted request; the pending index is latched from req_sel.
- req_sel >= NPROJ (13..15 at default) is accepted and mapped to pending = 0, matching the mux default arm.
- A request for the currently selected index is still fully sequenced; this is the way to re-reset a project.
- req_ready is 0 outside ACTIVE. Requests presented then are not accepted; the host holds req_valid.
- Autoscan, in ACTIVE with scan_en=1:
  - The dwell counter increments each cycle.
  - At DWELL_CYCLES-1 an internal request is issued with pending = sel+1, wrapping NPROJ-1 -> 0.
- A host request in the same cycle as the dwell expiry wins. The dwell counter clears on any transition and whenever scan_en=0.
- Reset asserted mid-sequence aborts immediately to the reset values. The pending index is discarded.

## Timing
- Accepting edge E0: blank=1, active=0, req_ready=0 from E0.
- sel updates at E0+GUARD_CYCLES.
- active=1 and proj_rst_n[sel]=1 at E0+GUARD_CYCLES+RST_CYCLES; defaults give 6 edges.
- After reset release: active=1 at the RST_CYCLES-th rising edge (4 by default).
- sel never changes while blank=0.
- All outputs are registered, with no combinational path from inputs to outputs. Exception: none; req_ready is decoded from state registers only.
- Back-to-back requests: the next one can be accepted on the first ACTIVE cycle.

## Configuration
- SCHED_AUTOSCAN_EN defined: the dwell counter and internal rotation are built; scan_en is honoured.
- SCHED_AUTOSCAN_EN undefined:
  - No dwell counter is synthesised; scan_en is unused.
  - The select changes only on host requests.
  - All other behaviour is identical.

## Test plan
- Reset release with DEFAULT_SEL=0 -> sel=0, blank=1 and proj_rst_n=0 for 4 edges; then active=1, proj_rst_n=13'h0001, blank=0.
- In ACTIVE, req_sel=5 for one cycle -> blank=1 at once; sel=5 at +2; proj_rst_n=13'h0020 and active=1 at +6; req_ready=0 during cycles +1..+5.
- req_sel=14 accepted -> sel=0 after sequencing; proj_rst_n[0] released.
- rst pulsed low during HOLDRST of a switch to 7 -> sel returns to DEFAULT_SEL and all outputs go to reset values immediately; the pending 7 is never applied.
- SCHED_AUTOSCAN_EN with DWELL_CYCLES=8 and scan_en=1 from sel=12 -> after 8 ACTIVE cycles, sel moves to 0 via the full BLANK/HOLDRST sequence; a host req_sel=3 on the expiry cycle -> sel=3.
- Hold req_valid=1 with req_sel=2 throughout a switch to 9 -> 9 completes first; 2 is accepted on the first ACTIVE cycle.
